four_phase_transfer: RTL and testbench
======================================

Name: four_phase_transfer

Overview:
Downstream consumer of the four-phase pulse generator's p1..p4 strobes. It runs one operand-load / compute / write-back transfer per complete p1→p2→p3→p4 sequence. It also checks phase ordering and counts completed transfers. It sits between the phase generator and the register/datapath logic that takes result.

Parameters:
WIDTH, 8, operand/result width in bits
CW, 8, cycle_count width in bits

Ports:
clock  input  1  system clock; all state updates on posedge clock
clear  input  1  asynchronous, active-high reset
enable  input  1  transfer enable; low forces the sequence back to idle
p1  input  1  phase-1 strobe: load operand A
p2  input  1  phase-2 strobe: load operand B
p3  input  1  phase-3 strobe: compute
p4  input  1  phase-4 strobe: write back
op  input  2  operation, sampled on the p3 event
data_in  input  WIDTH  operand bus, sampled on p1/p2 events
result  output  WIDTH  last written-back result
carry  output  1  carry/borrow of the last written-back result
result_valid  output  1  one-clock pulse on write-back
phase_err  output  1  sticky phase-order error
cycle_count  output  CW  completed transfers, modulo 2^CW

Behaviour:
- Interface: one clock, clock. Reset clear is asynchronous and active-high.
- Reset values: result=0, carry=0, result_valid=0, phase_err=0, cycle_count=0; internal A=B=R=0; FSM=IDLE; strobe history regs=0.
- p1..p4 are synchronous to clock and each strobe is high for ≥1 clock.
- Event detection: pN_q <= pN every clock. evN = pN & ~pN_q, i.e. the rising edge seen at the current posedge.
- multi = more than one evN in the same clock.
- FSM states: IDLE (expect p1), S1 (expect p2), S2 (expect p3), S3 (expect p4).
- IDLE: ev1 alone → A<=data_in, go to S1. Any other event is ignored (resync) with no error.
- S1: ev2 alone → B<=data_in, go to S2.
- S2: ev3 alone → R,Rc <= A op B, go to S3.
- S3: ev4 alone → result<=R, carry<=Rc, result_valid=1 for exactly that clock, cycle_count+1 (wraps 2^CW-1 → 0), go to IDLE.
- Error: in S1/S2/S3, any event other than the expected one, or multi → phase_err<=1, go to IDLE, discard A/B/R. result and cycle_count are unchanged.
- Error in IDLE: multi including ev1 → phase_err<=1, stay in IDLE, A unchanged.
- No event in a clock → state holds.
- phase_err is sticky; only clear resets it. Transfers continue after an error.
- enable=0: FSM synchronously goes to IDLE and all events are ignored. Strobe history still updates, so an already-high p1 does not fire when enable rises. result, carry, cycle_count and phase_err hold; result_valid=0.
- op encoding:
  - 00 ADD: R=A+B, Rc=carry-out.
  - 01 SUB: R=A-B, Rc=borrow (A<B).
  - 10 AND, Rc=0.
  - 11 XOR, Rc=0.
- Arithmetic is modulo 2^WIDTH; the carry bit is computed WIDTH+1 wide.
- Latency: result/carry/result_valid change at the same posedge that first samples p4 high in S3.
- clear mid-transfer: immediate return to reset values; the partial transfer is lost.

Decomposition:
- Shared package: FSM state encoding (IDLE/S1/S2/S3, 2 bits) and op codes (OP_ADD/SUB/AND/XOR).
- One natural sub-module, phase_edge_detect: four pN_q registers producing ev1..ev4 and multi.
- FSM, operand registers and ALU stay in the top.

Test Plan:
- clear, then enable=1; strobes p1(data_in=8'h3C), p2(8'h05), p3(op=00), p4, each 2 clocks wide with gaps → result=8'h41, carry=0, result_valid one clock at the p4 sample, cycle_count=1, phase_err=0.
- Same with A=8'hF0, B=8'h20, op=00 → result=8'h10, carry=1. Then A=8'h05, B=8'h07, op=01 → result=8'hFE, carry=1.
- p1, p2, then p4 (p3 skipped) → phase_err=1, no result_valid, result unchanged. A following correct sequence (AND, 8'hCC & 8'hAA) → result=8'h88; phase_err stays 1.
- p2 and p3 pulses while in IDLE → ignored, phase_err=0. p1 and p2 rising in the same clock → phase_err=1.
- CW=4: run 16 complete transfers → cycle_count wraps 15→0 on the 16th result_valid.
- clear asserted asynchronously mid-S2 → all outputs 0 immediately. enable dropped in S1 with p1 held high, then re-raised → no spurious A load, FSM in IDLE.

Source files
------------

// File: rtl/four_phase_transfer_pkg.sv
// Shared types for the four-phase transfer block.
//   state_e : transfer sequencer states (IDLE waits for p1, S1 for p2,
//             S2 for p3, S3 for p4)
//   op_e    : ALU operation codes sampled on the p3 event
package four_phase_transfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_S1   = 2'b01,
    ST_S2   = 2'b10,
    ST_S3   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

endpackage

// File: rtl/four_phase_transfer_if.sv
// Bus bundle between the phase generator / datapath side and the
// four_phase_transfer block.
//   master : drives enable, p1..p4, op, data_in; observes results
//   slave  : the transfer block itself
interface four_phase_transfer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 8
);
  logic             enable;
  logic             p1;
  logic             p2;
  logic             p3;
  logic             p4;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             result_valid;
  logic             phase_err;
  logic [CW-1:0]    cycle_count;

  modport master (
    output enable, p1, p2, p3, p4, op, data_in,
    input  result, carry, result_valid, phase_err, cycle_count
  );

  modport slave (
    input  enable, p1, p2, p3, p4, op, data_in,
    output result, carry, result_valid, phase_err, cycle_count
  );
endinterface

// File: rtl/four_phase_transfer_phase_edge_detect.sv
// Rising-edge detector for the four phase strobes.
//   clock, clear : clock and asynchronous active-high reset
//   p_i[3:0]     : strobes, bit 0 = p1 ... bit 3 = p4
//   ev_o[3:0]    : strobe rose at this posedge
//   multi_o      : more than one strobe rose at this posedge
module phase_edge_detect (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] p_i,
  output logic [3:0] ev_o,
  output logic       multi_o
);

  logic [3:0] p_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) p_q <= '0;
    else       p_q <= p_i;
  end

  assign ev_o    = p_i & ~p_q;
  // x & (x-1) clears the lowest set bit; anything left means two or more.
  assign multi_o = (ev_o & (ev_o - 4'd1)) != 4'd0;

endmodule

// File: rtl/four_phase_transfer.sv
// Consumes p1..p4 strobes and performs one load-A / load-B / compute /
// write-back transfer per correctly ordered sequence. Out-of-order or
// simultaneous strobes set a sticky phase error and resync to IDLE.
//   clock, clear : clock and asynchronous active-high reset
//   bus (slave)  : enable, p1..p4, op, data_in in;
//                  result, carry, result_valid, phase_err, cycle_count out
module four_phase_transfer
  import four_phase_transfer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  four_phase_transfer_if.slave  bus
);

  logic [3:0] ev;
  logic       multi;

  phase_edge_detect u_edge (
    .clock   (clock),
    .clear   (clear),
    .p_i     ({bus.p4, bus.p3, bus.p2, bus.p1}),
    .ev_o    (ev),
    .multi_o (multi)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic             rc_q, rc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   alu_w;

  // ALU is one bit wider so the top bit is carry-out (ADD) or borrow (SUB).
  always_comb begin
    alu_w = '0;
    unique case (op_e'(bus.op))
      OP_ADD: alu_w = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: alu_w = {1'b0, a_q} - {1'b0, b_q};
      OP_AND: alu_w = {1'b0, a_q & b_q};
      OP_XOR: alu_w = {1'b0, a_q ^ b_q};
      default: alu_w = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    rc_d     = rc_q;
    result_d = result_q;
    carry_d  = carry_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else if (ev != 4'd0) begin
      unique case (state_q)
        ST_IDLE: begin
          // Stray p2..p4 edges in IDLE are a resync, not an error.
          if (ev == 4'b0001) begin
            a_d     = bus.data_in;
            state_d = ST_S1;
          end else if (multi && ev[0]) begin
            err_d = 1'b1;
          end
        end
        ST_S1: begin
          if (ev == 4'b0010) begin
            b_d     = bus.data_in;
            state_d = ST_S2;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_S2: begin
          if (ev == 4'b0100) begin
            {rc_d, r_d} = alu_w;
            state_d     = ST_S3;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_S3: begin
          if (ev == 4'b1000) begin
            result_d = r_q;
            carry_d  = rc_q;
            valid_d  = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            state_d  = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      rc_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      rc_q     <= rc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.carry        = carry_q;
  assign bus.result_valid = valid_q;
  assign bus.phase_err    = err_q;
  assign bus.cycle_count  = cnt_q;

endmodule

// File: tb/tb_four_phase_transfer.sv
// Randomized and directed bench for four_phase_transfer, checked against a
// transaction-level model (phase progress counter plus integer arithmetic).
module tb_four_phase_transfer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = 4;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  four_phase_transfer_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  four_phase_transfer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_prog;   // phases of the current transfer already accepted
  int         m_a, m_b, m_r, m_rc;
  int         m_res, m_carry, m_valid, m_err, m_cnt;
  logic [3:0] m_prev;
  int         valid_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prog = 0; m_a = 0; m_b = 0; m_r = 0; m_rc = 0;
    m_res = 0; m_carry = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    m_prev = '0;
  endtask

  task automatic model_step();
    logic [3:0] p, ev;
    int n;
    p = {bus.p4, bus.p3, bus.p2, bus.p1};
    ev = p & ~m_prev;
    m_prev = p;
    n = $countones(ev);
    m_valid = 0;
    if (!bus.enable) begin
      m_prog = 0;
    end else if (n == 1 && ev[m_prog]) begin
      case (m_prog)
        0: m_a = int'(bus.data_in);
        1: m_b = int'(bus.data_in);
        2: begin
          case (int'(bus.op))
            0: begin m_r = (m_a + m_b) % (1 << WIDTH); m_rc = (m_a + m_b >= (1 << WIDTH)) ? 1 : 0; end
            1: begin m_r = (m_a - m_b + (1 << WIDTH)) % (1 << WIDTH); m_rc = (m_a < m_b) ? 1 : 0; end
            2: begin m_r = m_a & m_b; m_rc = 0; end
            default: begin m_r = m_a ^ m_b; m_rc = 0; end
          endcase
        end
        default: begin
          m_res = m_r; m_carry = m_rc; m_valid = 1;
          m_cnt = (m_cnt + 1) % (1 << CW);
        end
      endcase
      m_prog = (m_prog + 1) % 4;
    end else if (n != 0) begin
      if (m_prog != 0) begin
        m_err = 1;
        m_prog = 0;
      end else if (ev[0]) begin
        m_err = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("result", 32'(bus.result), 32'(m_res));
    check("carry", 32'(bus.carry), 32'(m_carry));
    check("result_valid", 32'(bus.result_valid), 32'(m_valid));
    check("phase_err", 32'(bus.phase_err), 32'(m_err));
    check("cycle_count", 32'(bus.cycle_count), 32'(m_cnt));
    if (bus.result_valid) valid_seen++;
  endtask

  task automatic set_p(input int idx, input logic v);
    case (idx)
      0: bus.p1 = v;
      1: bus.p2 = v;
      2: bus.p3 = v;
      default: bus.p4 = v;
    endcase
  endtask

  task automatic strobe(input int idx, input logic [7:0] d, input logic [1:0] o,
                        input int width, input int gap);
    bus.data_in = d;
    bus.op = o;
    set_p(idx, 1'b1);
    repeat (width) tick();
    set_p(idx, 1'b0);
    repeat (gap) tick();
  endtask

  task automatic transfer(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
    strobe(0, a, 2'b00, 2, 1);
    strobe(1, b, 2'b00, 2, 1);
    strobe(2, 8'h00, o, 2, 1);
    strobe(3, 8'h00, 2'b00, 2, 1);
  endtask

  // Call right after tick(): asserts clear between edges and releases it
  // before the next posedge.
  task automatic do_clear(input string tag);
    bus.p1 = 1'b0; bus.p2 = 1'b0; bus.p3 = 1'b0; bus.p4 = 1'b0;
    #2 clear = 1'b1;
    #1;
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_carry"}, 32'(bus.carry), 32'd0);
    check({tag, "_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_err"}, 32'(bus.phase_err), 32'd0);
    check({tag, "_count"}, 32'(bus.cycle_count), 32'd0);
    model_reset();
    #3 clear = 1'b0;
  endtask

  initial begin
    int v0;
    int c0;
    bus.enable = 1'b0;
    bus.p1 = 1'b0; bus.p2 = 1'b0; bus.p3 = 1'b0; bus.p4 = 1'b0;
    bus.op = 2'b00;
    bus.data_in = '0;
    model_reset();
    valid_seen = 0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_carry", 32'(bus.carry), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_err", 32'(bus.phase_err), 32'd0);
    check("rst_count", 32'(bus.cycle_count), 32'd0);
    clear = 1'b0;
    bus.enable = 1'b1;
    tick();

    // Basic ADD
    v0 = valid_seen;
    transfer(8'h3C, 8'h05, 2'b00);
    check("add1_result", 32'(bus.result), 32'h41);
    check("add1_carry", 32'(bus.carry), 32'd0);
    check("add1_pulses", 32'(valid_seen - v0), 32'd1);
    check("add1_count", 32'(bus.cycle_count), 32'd1);
    check("add1_err", 32'(bus.phase_err), 32'd0);

    transfer(8'hF0, 8'h20, 2'b00);
    check("add2_result", 32'(bus.result), 32'h10);
    check("add2_carry", 32'(bus.carry), 32'd1);
    transfer(8'h05, 8'h07, 2'b01);
    check("sub_result", 32'(bus.result), 32'hFE);
    check("sub_borrow", 32'(bus.carry), 32'd1);

    // Skipped p3
    v0 = valid_seen;
    strobe(0, 8'h12, 2'b00, 2, 1);
    strobe(1, 8'h34, 2'b00, 2, 1);
    strobe(3, 8'h00, 2'b00, 2, 1);
    check("skip_err", 32'(bus.phase_err), 32'd1);
    check("skip_pulses", 32'(valid_seen - v0), 32'd0);
    check("skip_result", 32'(bus.result), 32'hFE);
    transfer(8'hCC, 8'hAA, 2'b10);
    check("and_result", 32'(bus.result), 32'h88);
    check("and_err_sticky", 32'(bus.phase_err), 32'd1);

    // Stray strobes in IDLE, then simultaneous p1/p2
    do_clear("clr1");
    strobe(1, 8'h00, 2'b00, 1, 1);
    strobe(2, 8'h00, 2'b00, 2, 1);
    check("idle_stray_err", 32'(bus.phase_err), 32'd0);
    bus.p1 = 1'b1; bus.p2 = 1'b1;
    tick(); tick();
    bus.p1 = 1'b0; bus.p2 = 1'b0;
    tick();
    check("multi_err", 32'(bus.phase_err), 32'd1);

    // Counter wrap with CW=4
    do_clear("clr2");
    v0 = valid_seen;
    for (int i = 0; i < 15; i++) transfer(8'($urandom), 8'($urandom), 2'($urandom));
    check("wrap_15", 32'(bus.cycle_count), 32'd15);
    transfer(8'h01, 8'h02, 2'b11);
    check("wrap_0", 32'(bus.cycle_count), 32'd0);
    check("wrap_pulses", 32'(valid_seen - v0), 32'd16);

    // Asynchronous clear while waiting for p3
    strobe(0, 8'h55, 2'b00, 2, 1);
    strobe(1, 8'h66, 2'b00, 2, 1);
    do_clear("clr_s2");

    // enable dropped in S1 with p1 held high
    bus.enable = 1'b1;
    tick();
    bus.data_in = 8'h11;
    bus.p1 = 1'b1;
    tick(); tick();
    bus.enable = 1'b0;
    bus.data_in = 8'h77;
    tick(); tick();
    bus.enable = 1'b1;
    tick(); tick();
    bus.p1 = 1'b0;
    tick();
    v0 = valid_seen;
    c0 = int'(bus.cycle_count);
    strobe(1, 8'h01, 2'b00, 2, 1);
    strobe(2, 8'h00, 2'b00, 2, 1);
    strobe(3, 8'h00, 2'b00, 2, 1);
    check("en_no_pulse", 32'(valid_seen - v0), 32'd0);
    check("en_no_err", 32'(bus.phase_err), 32'd0);
    check("en_count", 32'(bus.cycle_count), 32'(c0));
    transfer(8'h21, 8'h01, 2'b00);
    check("en_after_result", 32'(bus.result), 32'h22);

    // Randomized sequences with occasional faults and enable drops
    for (int k = 0; k < 300; k++) begin
      int r;
      int ph;
      int ph2;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
      end else if (r < 12) begin
        ph = $urandom_range(0, 3);
        ph2 = (ph + $urandom_range(1, 3)) % 4;
        set_p(ph, 1'b1);
        set_p(ph2, 1'b1);
        repeat ($urandom_range(1, 2)) tick();
        set_p(ph, 1'b0);
        set_p(ph2, 1'b0);
        tick();
      end else begin
        ph = (r < 85) ? m_prog : $urandom_range(0, 3);
        strobe(ph, 8'($urandom), 2'($urandom), $urandom_range(1, 3), $urandom_range(0, 2));
      end
      if ($urandom_range(0, 99) < 2) begin
        tick();
        do_clear("rnd_clr");
      end
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
